// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the IF and DM requesters, the arbiter and the memory port.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 30
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;

   logic              dm_read;
   logic              dm_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [3:0]        dm_be;
   logic [31:0]       dm_rdata;
   logic              dm_ready;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be,
      input  mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
   );

   modport master (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_be,
      output mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and DM, one transaction at a time; request to ready is 2 cycles minimum.
// Requesters hold until their ready pulse; DM has priority until IF has waited STARVE_LIMIT grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 30,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

   state_t            state, state_nxt;
   logic              dm_req;
   logic              grant_dm;
   logic              grant_if;
   logic [3:0]        starve_cnt;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       if_rdata;
   logic              if_ready;
   logic [31:0]       dm_rdata;
   logic              dm_ready;
   logic              busy;

   always_comb begin
      dm_req    = bus.dm_read | bus.dm_write;
      grant_dm  = 1'b0;
      grant_if  = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dm_req && !(bus.if_req && starve_cnt == LIMIT)) begin
               grant_dm  = 1'b1;
               state_nxt = DATA;
            end else if (bus.if_req) begin
               grant_if  = 1'b1;
               state_nxt = INST;
            end
         end
         INST, DATA: begin
            if (bus.mem_ack) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         if_rdata   <= '0;
         if_ready   <= 1'b0;
         dm_rdata   <= '0;
         dm_ready   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         if_ready <= 1'b0;
         dm_ready <= 1'b0;

         if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= bus.dm_write;
            mem_addr  <= bus.dm_addr;
            mem_wdata <= bus.dm_wdata;
            mem_be    <= bus.dm_write ? bus.dm_be : 4'hF;
            // Count only grants that actually made IF wait.
            if (!bus.if_req)
               starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 4'd1;
         end else if (grant_if) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= bus.if_addr;
            mem_wdata  <= '0;
            mem_be     <= 4'hF;
            starve_cnt <= '0;
         end

         if ((state == INST || state == DATA) && bus.mem_ack) begin
            mem_req <= 1'b0;
            if (state == INST) begin
               if_rdata <= bus.mem_rdata;
               if_ready <= 1'b1;
            end else begin
               dm_ready <= 1'b1;
               if (!mem_we) dm_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_be    = mem_be;
   assign bus.if_rdata  = if_rdata;
   assign bus.if_ready  = if_ready;
   assign bus.dm_rdata  = dm_rdata;
   assign bus.dm_ready  = dm_ready;
   assign bus.busy      = busy;
endmodule
